// File: rtl/pwm_sample_sched_if.sv
// Sample-source and PWM-stage signals of the round-robin sample scheduler.
// master = the side supplying samples and consuming the PWM sample, slave = the scheduler.
interface pwm_sample_sched_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 2
);
  localparam int CHW = $clog2(NCH);

  logic                    en;
  logic [NCH-1:0]          ch_mask;
  logic [NCH-1:0]          in_valid;
  logic [NCH*WIDTH-1:0]    in_data;
  logic [NCH-1:0]          in_ready;
  logic signed [WIDTH-1:0] sample_out;
  logic                    sample_stb;
  logic [CHW-1:0]          sample_ch;
  logic                    underrun;
  logic                    busy;

  modport master (
    output en, ch_mask, in_valid, in_data,
    input  in_ready, sample_out, sample_stb, sample_ch, underrun, busy
  );

  modport slave (
    input  en, ch_mask, in_valid, in_data,
    output in_ready, sample_out, sample_stb, sample_ch, underrun, busy
  );
endinterface

// File: rtl/pwm_sample_sched.sv
// Round-robin scheduler pulling one sample per DIV-cycle period from the next enabled source.
// Strobe DIV cycles after each period start; a source that is not valid by the tick is an underrun.
module pwm_sample_sched #(
  parameter int WIDTH = 16,
  parameter int NCH   = 2,
  parameter int DIV   = 256
) (
  input  logic              clk,
  input  logic              rst,
  pwm_sample_sched_if.slave bus
);
  localparam int CHW = $clog2(NCH);
  localparam int CW  = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, ARB, FETCH, HOLD} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [CHW-1:0]          ptr;
  logic [CHW-1:0]          grant;
  logic [CHW-1:0]          nxt;
  logic [CHW-1:0]          idx;
  logic                    found;
  logic                    tick;
  logic                    hs;
  logic signed [WIDTH-1:0] pending;
  logic signed [WIDTH-1:0] grant_dat;

  assign tick     = (cnt == CW'(DIV - 1));
  assign hs       = (state == FETCH) && (|(bus.in_valid & bus.in_ready));
  assign bus.busy = (state != IDLE);

  // Modulo-NCH search starting after the last grant; works for non-power-of-two NCH.
  always_comb begin
    nxt   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CHW'((int'(ptr) + i) % NCH);
      if (!found && bus.ch_mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant == CHW'(k)) grant_dat = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      ptr            <= CHW'(NCH - 1);
      grant          <= '0;
      pending        <= '0;
      bus.sample_out <= '0;
      bus.sample_stb <= 1'b0;
      bus.sample_ch  <= '0;
      bus.in_ready   <= '0;
      bus.underrun   <= 1'b0;
    end else begin
      bus.sample_stb <= 1'b0;
      if (!bus.en || state == IDLE || tick) cnt <= '0;
      else                                  cnt <= cnt + 1'b1;

      if (!bus.en) begin
        // Abandon the period silently: no strobe, pending sample discarded.
        state          <= IDLE;
        bus.in_ready   <= '0;
        bus.sample_out <= '0;
        pending        <= '0;
        bus.underrun   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bus.sample_out <= '0;
            bus.in_ready   <= '0;
            bus.underrun   <= 1'b0;
            state          <= ARB;
          end
          ARB: begin
            if (bus.ch_mask != '0) begin
              grant        <= nxt;
              bus.in_ready <= NCH'(1) << nxt;
              state        <= FETCH;
            end else begin
              grant   <= ptr;
              pending <= '0;
              state   <= HOLD;
            end
          end
          FETCH: begin
            if (hs) begin
              bus.in_ready <= '0;
              if (tick) begin
                // Late arrival on the tick still makes this period's strobe.
                bus.sample_out <= grant_dat;
                bus.sample_ch  <= grant;
                bus.sample_stb <= 1'b1;
                ptr            <= grant;
                state          <= ARB;
              end else begin
                pending <= grant_dat;
                state   <= HOLD;
              end
            end else if (tick) begin
              bus.in_ready   <= '0;
              bus.sample_out <= '0;
              bus.sample_ch  <= grant;
              bus.sample_stb <= 1'b1;
              bus.underrun   <= 1'b1;
              ptr            <= grant;
              state          <= ARB;
            end
          end
          HOLD: begin
            if (tick) begin
              bus.sample_out <= pending;
              bus.sample_ch  <= grant;
              bus.sample_stb <= 1'b1;
              ptr            <= grant;
              state          <= ARB;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
